// File: rtl/trng_harvester.sv
// rtl/trng_harvester.sv - Entropy harvester: sampler, repetition health test, von Neumann debias, packer, FIFO.
//
// Samples the XOR-reduced parity of entropy_in every SAMPLE_DIV cycles. A
// repetition-count health test raises a sticky fault when REP_LIMIT identical
// raw samples are seen in a row. Healthy samples are debiased pairwise
// (von Neumann), packed MSB-first into 32-bit words and buffered in a FIFO
// that is read through a two-register read port.
//
// Ports:
//   clk         - single clock, rising edge
//   rst_n       - asynchronous active-low reset
//   entropy_in  - free-running synchronized rng output
//   enable      - gates the sample divider and all harvesting stages
//   clear_fault - strobe: clears fault and restarts the health test and packer
//   rd_en       - read strobe
//   rd_addr     - 0 = DATA (pops FIFO head), 1 = STATUS (clears overflow)
//   rdata       - registered read data, valid the cycle after rd_en
//   data_avail  - FIFO holds at least one word
//   fault       - sticky repetition-count fault
module trng_harvester #(
    parameter int SAMPLE_DIV = 16,
    parameter int REP_LIMIT  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] entropy_in,
    input  logic        enable,
    input  logic        clear_fault,
    input  logic        rd_en,
    input  logic        rd_addr,
    output logic [31:0] rdata,
    output logic        data_avail,
    output logic        fault
);

    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
    localparam logic [7:0] REP_MAX  = 8'(REP_LIMIT);
    localparam logic [4:0] DEPTH_C  = 5'(FIFO_DEPTH);

    typedef enum logic {
        DB_IDLE       = 1'b0,
        DB_HAVE_FIRST = 1'b1
    } db_state_e;

    logic [7:0]  div_q, div_d;
    logic [7:0]  rep_q, rep_d;
    logic        prev_raw_q, prev_raw_d;
    logic        fault_q, fault_d;
    db_state_e   db_state_q, db_state_d;
    logic        db_bit_q, db_bit_d;
    logic [31:0] word_q, word_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]  count_q;
    logic        ovf_q;
    logic [31:0] rdata_q;
    logic [31:0] mem [FIFO_DEPTH];

    logic        tick;
    logic        raw;
    logic [7:0]  rep_next;
    logic        fault_trip;
    logic        accept;
    logic        emit;
    logic [31:0] word_next;
    logic        push;
    logic        pop;
    logic        full;
    logic        push_ok;
    logic        overflow_evt;

    assign tick = enable && (div_q == DIV_LAST);
    assign raw  = ^entropy_in;

    // rep_q == 0 marks "no previous sample" after reset or clear_fault.
    // Saturate so a long run while already faulted cannot wrap back to 1.
    assign rep_next = ((rep_q == 8'd0) || (raw != prev_raw_q)) ? 8'd1 :
                      ((rep_q == 8'hFF) ? rep_q : rep_q + 8'd1);

    assign fault_trip = tick && !clear_fault && !fault_q && (rep_next == REP_MAX);

    // The sample that trips the fault is not fed downstream either.
    assign accept    = tick && !clear_fault && !fault_q && !fault_trip;
    assign emit      = accept && (db_state_q == DB_HAVE_FIRST) && (raw != db_bit_q);
    assign word_next = {word_q[30:0], db_bit_q};
    assign push      = emit && (bit_cnt_q == 5'd31);

    assign pop          = rd_en && !rd_addr && (count_q != 5'd0);
    assign full         = (count_q == DEPTH_C);
    // A same-cycle pop frees the head slot, so a full FIFO still accepts.
    assign push_ok      = push && (!full || pop);
    assign overflow_evt = push && full && !pop;

    always_comb begin
        div_d      = div_q;
        rep_d      = rep_q;
        prev_raw_d = prev_raw_q;
        fault_d    = fault_q;
        db_state_d = db_state_q;
        db_bit_d   = db_bit_q;
        word_d     = word_q;
        bit_cnt_d  = bit_cnt_q;

        if (enable) begin
            div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
        end

        if (clear_fault) begin
            rep_d      = 8'd0;
            fault_d    = 1'b0;
            db_state_d = DB_IDLE;
            word_d     = 32'd0;
            bit_cnt_d  = 5'd0;
        end else if (tick) begin
            rep_d      = rep_next;
            prev_raw_d = raw;
            if (fault_trip) begin
                // Discard the partial word and any half-formed pair.
                fault_d    = 1'b1;
                db_state_d = DB_IDLE;
                bit_cnt_d  = 5'd0;
            end else if (!fault_q) begin
                case (db_state_q)
                    DB_IDLE: begin
                        db_bit_d   = raw;
                        db_state_d = DB_HAVE_FIRST;
                    end
                    default: begin
                        db_state_d = DB_IDLE;
                    end
                endcase
                if (emit) begin
                    word_d    = word_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= 8'd0;
            rep_q      <= 8'd0;
            prev_raw_q <= 1'b0;
            fault_q    <= 1'b0;
            db_state_q <= DB_IDLE;
            db_bit_q   <= 1'b0;
            word_q     <= 32'd0;
            bit_cnt_q  <= 5'd0;
        end else begin
            div_q      <= div_d;
            rep_q      <= rep_d;
            prev_raw_q <= prev_raw_d;
            fault_q    <= fault_d;
            db_state_q <= db_state_d;
            db_bit_q   <= db_bit_d;
            word_q     <= word_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
            ovf_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 5'd1;
            end else if (!push_ok && pop) begin
                count_q <= count_q - 5'd1;
            end

            // A new overflow in the same cycle as a STATUS read stays visible.
            if (overflow_evt) begin
                ovf_q <= 1'b1;
            end else if (rd_en && rd_addr) begin
                ovf_q <= 1'b0;
            end

            if (rd_en) begin
                if (rd_addr) begin
                    rdata_q <= {24'd0, ovf_q, fault_q, 1'b0, count_q};
                end else if (count_q != 5'd0) begin
                    rdata_q <= mem[rd_ptr_q];
                end else begin
                    rdata_q <= 32'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= word_next;
        end
    end

    assign rdata      = rdata_q;
    assign data_avail = (count_q != 5'd0);
    assign fault      = fault_q;

endmodule

// File: tb/tb_trng_harvester.sv
// tb/tb_trng_harvester.sv - Self-checking bench for trng_harvester.
module tb_trng_harvester;

    localparam int SAMPLE_DIV = 16;
    localparam int REP_LIMIT  = 32;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] entropy = 32'd0;
    logic        enable = 1'b0;
    logic        clear_fault = 1'b0;
    logic        rd_en = 1'b0;
    logic        rd_addr = 1'b0;
    logic [31:0] rdata;
    logic        data_avail;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    trng_harvester #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .REP_LIMIT (REP_LIMIT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .entropy_in (entropy),
        .enable     (enable),
        .clear_fault(clear_fault),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rdata      (rdata),
        .data_avail (data_avail),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Reference model: behaviour in terms of ticks, bit pairs and a word queue.
    int          m_div;
    int          m_rep;
    bit          m_prev;
    bit          m_fault;
    bit          m_hf;
    bit          m_first;
    logic [31:0] m_word;
    int          m_bits;
    bit          m_ovf;
    logic [31:0] m_rdata;
    logic [31:0] m_q[$];

    task automatic m_reset();
        m_div = 0; m_rep = 0; m_prev = 0; m_fault = 0; m_hf = 0; m_first = 0;
        m_word = 0; m_bits = 0; m_ovf = 0; m_rdata = 0;
        m_q.delete();
    endtask

    task automatic model_cycle();
        bit tick, raw, pop, push;
        logic [31:0] pw;
        tick = enable && (m_div == SAMPLE_DIV - 1);
        raw  = ^entropy;
        pop  = rd_en && !rd_addr && (m_q.size() != 0);
        push = 0;
        pw   = 0;
        if (rd_en) begin
            if (rd_addr) m_rdata = {24'd0, m_ovf, m_fault, 1'b0, 5'(m_q.size())};
            else         m_rdata = (m_q.size() != 0) ? m_q[0] : 32'd0;
        end
        if (clear_fault) begin
            m_fault = 0; m_rep = 0; m_hf = 0; m_word = 0; m_bits = 0;
        end else if (tick) begin
            if (m_rep == 0 || raw != m_prev) m_rep = 1;
            else if (m_rep < 255)           m_rep = m_rep + 1;
            m_prev = raw;
            if (!m_fault) begin
                if (m_rep == REP_LIMIT) begin
                    m_fault = 1; m_hf = 0; m_bits = 0;
                end else if (!m_hf) begin
                    m_hf = 1; m_first = raw;
                end else begin
                    m_hf = 0;
                    if (raw != m_first) begin
                        m_word = {m_word[30:0], m_first};
                        m_bits = m_bits + 1;
                        if (m_bits == 32) begin
                            push = 1; pw = m_word; m_bits = 0;
                        end
                    end
                end
            end
        end
        if (enable) m_div = (m_div == SAMPLE_DIV - 1) ? 0 : m_div + 1;
        if (rd_en && rd_addr) m_ovf = 0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back(pw);
            else m_ovf = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: model advances with the applied inputs, outputs compared #1 after the edge.
    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        vectors++;
        if (rdata !== m_rdata || data_avail !== (m_q.size() != 0) || fault !== m_fault) begin
            miscompares++;
            $display("FAIL model t=%0t: rdata %h/%h avail %b/%b fault %b/%b", $time,
                     rdata, m_rdata, data_avail, (m_q.size() != 0), fault, m_fault);
        end
    endtask

    function automatic logic [31:0] ent_par(input bit p);
        logic [31:0] v;
        int k;
        v = $urandom;
        if ((^v) != p) begin
            k = $urandom_range(31, 0);
            v[k] = ~v[k];
        end
        return v;
    endfunction

    // Run cycles until exactly one sample tick has occurred with raw parity p.
    task automatic tick_with(input bit p, input bit rd_at_tick, input bit use_const);
        bit was_tick;
        was_tick = 0;
        enable = 1;
        while (!was_tick) begin
            entropy  = use_const ? 32'h0000_0001 : ent_par(p);
            was_tick = (m_div == SAMPLE_DIV - 1);
            rd_en    = rd_at_tick && was_tick;
            rd_addr  = 0;
            step();
            rd_en = 0;
        end
    endtask

    task automatic emit_ones(input int n);
        for (int i = 0; i < n; i++) begin tick_with(1, 0, 0); tick_with(0, 0, 0); end
    endtask

    task automatic emit_zeros(input int n);
        for (int i = 0; i < n; i++) begin tick_with(0, 0, 0); tick_with(1, 0, 0); end
    endtask

    // (0,1),(0,0),(1,0) repeated: emitted bits 0,1,0,1...
    task automatic emit_5555();
        for (int i = 0; i < 16; i++) begin
            tick_with(0, 0, 0); tick_with(1, 0, 0);
            tick_with(0, 0, 0); tick_with(0, 0, 0);
            tick_with(1, 0, 0); tick_with(0, 0, 0);
        end
    endtask

    task automatic bus_read(input bit addr);
        rd_en = 1; rd_addr = addr;
        step();
        rd_en = 0;
    endtask

    task automatic do_clear();
        clear_fault = 1;
        step();
        clear_fault = 0;
    endtask

    typedef struct {
        bit          rd_en;
        bit          rd_addr;
        logic [31:0] exp_rdata;
        bit          exp_avail;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 1, 32'h0000_0084, 1};
        tbl[1] = '{1, 1, 32'h0000_0004, 1};
        tbl[2] = '{0, 0, 32'h0000_0004, 1};
        tbl[3] = '{1, 0, 32'hFFFF_FFFF, 1};
        tbl[4] = '{1, 1, 32'h0000_0003, 1};
        tbl[5] = '{1, 0, 32'hFFFF_FFFF, 1};
        tbl[6] = '{1, 0, 32'hFFFF_FFFF, 1};
        tbl[7] = '{1, 0, 32'hFFFF_FFFF, 0};
        tbl[8] = '{1, 1, 32'h0000_0000, 0};
        tbl[9] = '{1, 0, 32'h0000_0000, 0};

        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'd0);
        check("reset_avail", {31'd0, data_avail}, 32'd0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        rst_n = 1;

        // Alternating parity: every pair emits a 1.
        emit_ones(32);
        check("alt_64ticks_avail", {31'd0, data_avail}, 32'd1);
        emit_ones(32 * 4);
        // FIFO now full plus one dropped word; drain through the table.
        enable = 0;
        for (int i = 0; i < 10; i++) begin
            rd_en = tbl[i].rd_en; rd_addr = tbl[i].rd_addr;
            step();
            rd_en = 0;
            check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_avail", i), {31'd0, data_avail}, {31'd0, tbl[i].exp_avail});
        end

        // Constant parity: fault exactly on the 32nd tick, twice.
        for (int r = 0; r < 2; r++) begin
            enable = 1; entropy = 32'h0000_0001;
            do_clear();
            check("clear_fault", {31'd0, fault}, 32'd0);
            for (int i = 0; i < REP_LIMIT; i++) begin
                tick_with(1, 0, 1);
                check($sformatf("rep%0d_tick%0d_fault", r, i + 1), {31'd0, fault},
                      {31'd0, (i == REP_LIMIT - 1)});
            end
            bus_read(1);
            check("rep_status", rdata, 32'h0000_0040);
        end

        // Debias of mixed pairs.
        do_clear();
        emit_5555();
        bus_read(0);
        check("debias_5555", rdata, 32'h5555_5555);

        // Pop coinciding with push on a full FIFO.
        emit_ones(32);
        emit_zeros(32 * 3);
        emit_zeros(31);
        tick_with(0, 0, 0);
        tick_with(1, 1, 0);
        check("pop_push_oldest", rdata, 32'hFFFF_FFFF);
        bus_read(1);
        check("pop_push_status", rdata, 32'h0000_0004);

        // Drain, empty read, then reset mid-packing.
        for (int i = 0; i < 4; i++) bus_read(0);
        bus_read(0);
        check("empty_read", rdata, 32'd0);
        emit_ones(32);
        emit_ones(17);
        bus_read(1);
        check("pre_reset_status", rdata, 32'h0000_0001);
        #2;
        rst_n = 0;
        #1;
        check("midreset_rdata", rdata, 32'd0);
        check("midreset_avail", {31'd0, data_avail}, 32'd0);
        check("midreset_fault", {31'd0, fault}, 32'd0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        emit_5555();
        bus_read(1);
        check("post_reset_status", rdata, 32'h0000_0001);
        bus_read(0);
        check("post_reset_word", rdata, 32'h5555_5555);

        // Randomized traffic against the model.
        begin
            int mode;
            bit alt;
            mode = 0; alt = 0;
            for (int c = 0; c < 6000; c++) begin
                if ((c % 300) == 0) mode = $urandom_range(2, 0);
                alt = ~alt;
                case (mode)
                    0:       entropy = $urandom;
                    1:       entropy = ent_par(1);
                    default: entropy = ent_par(alt);
                endcase
                enable      = ($urandom_range(9, 0) != 0);
                rd_en       = ($urandom_range(3, 0) == 0);
                rd_addr     = $urandom_range(1, 0);
                clear_fault = ($urandom_range(399, 0) == 0);
                step();
            end
            rd_en = 0; clear_fault = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
